// File: rtl/up_dn_seq.sv
// up_dn_seq: command sequencer for a WIDTH-bit up/down counter.
// Accepts LOAD / GOTO / SWEEP / ABORT, issues one counter strobe at a time,
// waits out the counter's register latency, and reports ok / abort / stuck.
// Strobes are registered: the step decision is made on the edge that enters
// ISSUE, using the counter value that is already stable in IDLE or CHECK.
module up_dn_seq #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] counter,
  input  logic             high,
  input  logic             low,
  output logic             load,
  output logic             up,
  output logic             down,
  output logic [WIDTH-1:0] cnt_in,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_GOTO  = 2'b01;
  localparam logic [1:0] OP_SWEEP = 2'b10;
  localparam logic [1:0] OP_ABORT = 2'b11;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_ABORT = 2'b01;
  localparam logic [1:0] ST_STUCK = 2'b10;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = WIDTH'(0);

  logic [2:0]       r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_tgt;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_rt;
  logic             r_dir_up;
  logic             r_abort_pend;
  logic             r_iss_fin;
  logic [1:0]       r_iss_stat;
  logic             r_ready;
  logic             r_load;
  logic             r_up;
  logic             r_down;
  logic [WIDTH-1:0] r_cnt_in;
  logic             r_busy;
  logic             r_done;
  logic [1:0]       r_status;

  logic             w_from_idle;
  logic             w_accept;
  logic             w_abort_acc;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_tgt;
  logic             w_dir_in;
  logic [WIDTH-1:0] w_rt_in;
  logic             w_sw_dir;
  logic [WIDTH-1:0] w_sw_rt;
  logic             w_sw_fin;
  logic             w_nx_load;
  logic             w_nx_up;
  logic             w_nx_down;
  logic             w_nx_fin;
  logic [1:0]       w_nx_stat;
  logic             w_nx_dir;
  logic [WIDTH-1:0] w_nx_rt;

  assign cmd_ready = r_ready;
  assign load      = r_load;
  assign up        = r_up;
  assign down      = r_down;
  assign cnt_in    = r_cnt_in;
  assign busy      = r_busy;
  assign done      = r_done;
  assign status    = r_status;

  // Handshake qualifiers: a real command starts only from IDLE, abort only while busy.
  always_comb begin
    w_from_idle = (r_state == S_IDLE);
    w_accept    = w_from_idle && cmd_valid && r_ready && (cmd_op != OP_ABORT);
    w_abort_acc = cmd_valid && (cmd_op == OP_ABORT) && r_busy;
  end

  // Next-step decision for the ISSUE cycle, fed by the new command or the latched one.
  always_comb begin
    w_op      = w_from_idle ? cmd_op : r_op;
    w_tgt     = w_from_idle ? cmd_data : r_tgt;
    w_dir_in  = w_from_idle ? 1'b1 : r_dir_up;
    if (w_from_idle) begin
      w_rt_in = (cmd_data == ZERO) ? ONE : cmd_data;
    end else begin
      w_rt_in = r_rt;
    end
    w_sw_dir  = w_dir_in;
    w_sw_rt   = w_rt_in;
    w_sw_fin  = 1'b0;
    w_nx_load = 1'b0;
    w_nx_up   = 1'b0;
    w_nx_down = 1'b0;
    w_nx_fin  = 1'b0;
    w_nx_stat = ST_OK;
    w_nx_dir  = w_dir_in;
    w_nx_rt   = w_rt_in;

    case (w_op)
      OP_LOAD: begin
        w_nx_load = 1'b1;
      end
      OP_GOTO: begin
        if (counter == w_tgt) begin
          w_nx_fin = 1'b1;
        end else if (counter < w_tgt) begin
          if (high) begin
            w_nx_fin  = 1'b1;
            w_nx_stat = ST_STUCK;
          end else begin
            w_nx_up = 1'b1;
          end
        end else begin
          if (low) begin
            w_nx_fin  = 1'b1;
            w_nx_stat = ST_STUCK;
          end else begin
            w_nx_down = 1'b1;
          end
        end
      end
      OP_SWEEP: begin
        // Turn around at the top; at the bottom one round trip is complete.
        if (w_sw_dir && high) begin
          w_sw_dir = 1'b0;
        end else begin
          w_sw_dir = w_sw_dir;
        end
        if (!w_sw_dir && low) begin
          w_sw_rt = w_sw_rt - ONE;
          if (w_sw_rt == ZERO) begin
            w_sw_fin = 1'b1;
          end else begin
            w_sw_dir = 1'b1;
          end
        end else begin
          w_sw_rt = w_sw_rt;
        end
        w_nx_dir = w_sw_dir;
        w_nx_rt  = w_sw_rt;
        if (w_sw_fin) begin
          w_nx_fin = 1'b1;
        end else if (w_sw_dir) begin
          if (high) begin
            w_nx_fin  = 1'b1;
            w_nx_stat = ST_STUCK;
          end else begin
            w_nx_up = 1'b1;
          end
        end else begin
          if (low) begin
            w_nx_fin  = 1'b1;
            w_nx_stat = ST_STUCK;
          end else begin
            w_nx_down = 1'b1;
          end
        end
      end
      default: begin
        w_nx_fin = 1'b1;
      end
    endcase

    // An abort arriving in CHECK suppresses the next strobe and finishes from ISSUE.
    if (w_abort_acc) begin
      w_nx_load = 1'b0;
      w_nx_up   = 1'b0;
      w_nx_down = 1'b0;
      w_nx_fin  = 1'b1;
      w_nx_stat = ST_ABORT;
    end else begin
      w_nx_fin = w_nx_fin;
    end
  end

  // Sequencer state machine with registered strobes, handshake and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= 2'b00;
      r_tgt        <= ZERO;
      r_cap        <= ZERO;
      r_rt         <= ZERO;
      r_dir_up     <= 1'b1;
      r_abort_pend <= 1'b0;
      r_iss_fin    <= 1'b0;
      r_iss_stat   <= ST_OK;
      r_ready      <= 1'b0;
      r_load       <= 1'b0;
      r_up         <= 1'b0;
      r_down       <= 1'b0;
      r_cnt_in     <= ZERO;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_status     <= ST_OK;
    end else begin
      r_load   <= 1'b0;
      r_up     <= 1'b0;
      r_down   <= 1'b0;
      r_done   <= 1'b0;
      r_status <= ST_OK;
      if (w_abort_acc) begin
        r_abort_pend <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_ready      <= 1'b1;
          r_abort_pend <= 1'b0;
          if (w_accept) begin
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_op       <= cmd_op;
            r_tgt      <= cmd_data;
            r_load     <= w_nx_load;
            r_up       <= w_nx_up;
            r_down     <= w_nx_down;
            r_dir_up   <= w_nx_dir;
            r_rt       <= w_nx_rt;
            r_iss_fin  <= w_nx_fin;
            r_iss_stat <= w_nx_stat;
            if (w_nx_load) begin
              r_cnt_in <= cmd_data;
            end
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cap <= counter;
          if (r_iss_fin) begin
            r_state  <= S_FIN;
            r_done   <= 1'b1;
            r_status <= r_iss_stat;
            r_busy   <= 1'b0;
          end else begin
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (r_abort_pend) begin
            r_state  <= S_FIN;
            r_done   <= 1'b1;
            r_status <= ST_ABORT;
            r_busy   <= 1'b0;
          end else if (r_op == OP_LOAD) begin
            r_state  <= S_FIN;
            r_done   <= 1'b1;
            r_status <= (counter == r_tgt) ? ST_OK : ST_STUCK;
            r_busy   <= 1'b0;
          end else if (counter == r_cap) begin
            r_state  <= S_FIN;
            r_done   <= 1'b1;
            r_status <= ST_STUCK;
            r_busy   <= 1'b0;
          end else begin
            r_up       <= w_nx_up;
            r_down     <= w_nx_down;
            r_dir_up   <= w_nx_dir;
            r_rt       <= w_nx_rt;
            r_iss_fin  <= w_nx_fin;
            r_iss_stat <= w_nx_stat;
            r_state    <= S_ISSUE;
          end
        end
        S_FIN: begin
          r_state      <= S_IDLE;
          r_ready      <= 1'b1;
          r_abort_pend <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_up_dn_seq.sv
// Bench for up_dn_seq: behavioural 5-bit counter, directed commands, and a
// scoreboard of expected per-command results checked by a done-driven monitor.
module tb_up_dn_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [4:0] cmd_data = 5'd0;
  logic [4:0] counter;
  logic       high, low;
  logic       load, up, down;
  logic [4:0] cnt_in;
  logic       busy, done;
  logic [1:0] status;

  logic       hold = 1'b0;
  logic [4:0] m_cnt = 5'd0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] st;
    int         ups;
    int         dns;
    int         lds;
    logic [4:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  up_dn_seq #(.WIDTH(5)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .counter(counter), .high(high),
    .low(low), .load(load), .up(up), .down(down), .cnt_in(cnt_in),
    .busy(busy), .done(done), .status(status)
  );

  always #5 clk = ~clk;

  // Counter block model; hold freezes it to emulate a stuck counter.
  always @(posedge clk) begin
    if (!hold) begin
      if (load) m_cnt <= cnt_in;
      else if (up) m_cnt <= m_cnt + 5'd1;
      else if (down) m_cnt <= m_cnt - 5'd1;
    end
  end
  assign counter = m_cnt;
  assign high    = (m_cnt == 5'd31);
  assign low     = (m_cnt == 5'd0);

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_cmd(input logic [1:0] st, input int ups, input int dns,
                            input int lds, input logic [4:0] cnt);
    exp_t e;
    e.st = st; e.ups = ups; e.dns = dns; e.lds = lds; e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  task automatic send(input logic [1:0] op, input logic [4:0] d);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", n, 0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) chk("done_timeout", n, 0);
    @(negedge clk);
  endtask

  // Monitor: strobe legality and spacing, per-command tallies, scoreboard pop on done.
  initial begin : monitor
    int cyc = 0, last = -1, m_up = 0, m_dn = 0, m_ld = 0, nstb;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        m_up = 0; m_dn = 0; m_ld = 0; last = -1;
      end else begin
        nstb = int'(load) + int'(up) + int'(down);
        if (nstb != 0) begin
          chk("strobe_onehot", nstb, 1);
          if (last >= 0) chk("strobe_spacing", cyc - last, 3);
          last = cyc;
        end
        m_up += int'(up); m_dn += int'(down); m_ld += int'(load);
        if (done) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb_q.pop_front();
            chk("sb_status", int'(status), int'(e.st));
            chk("sb_ups", m_up, e.ups);
            chk("sb_downs", m_dn, e.dns);
            chk("sb_loads", m_ld, e.lds);
            chk("sb_counter", int'(counter), int'(e.cnt));
            chk("sb_busy_at_done", int'(busy), 0);
          end
          m_up = 0; m_dn = 0; m_ld = 0; last = -1;
        end
      end
    end
  end

  // Directed stimulus sequence.
  initial begin : stim
    int ups;
    int n;
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_strobes", int'(load) + int'(up) + int'(down), 0);
    chk("rst_busy_done", int'(busy) + int'(done), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(cmd_ready), 1);

    // LOAD 17 with cycle-accurate checks
    expect_cmd(2'b00, 0, 0, 1, 5'd17);
    send(2'b00, 5'd17);
    @(negedge clk);
    chk("load_c1_strobe", int'(load), 1);
    chk("load_c1_cnt_in", int'(cnt_in), 17);
    chk("load_c1_busy", int'(busy), 1);
    chk("load_c1_ready", int'(cmd_ready), 0);
    @(negedge clk);
    chk("load_c2_busy", int'(busy), 1);
    chk("load_c2_counter", int'(counter), 17);
    @(negedge clk);
    chk("load_c3_busy", int'(busy), 1);
    chk("load_c3_done", int'(done), 0);
    @(negedge clk);
    chk("load_c4_done", int'(done), 1);
    chk("load_c4_busy", int'(busy), 0);
    @(negedge clk);
    chk("fin_next_ready", int'(cmd_ready), 1);
    chk("cnt_in_held", int'(cnt_in), 17);

    // GOTO 7 from 3, then GOTO 7 again (no strobes)
    expect_cmd(2'b00, 0, 0, 1, 5'd3);
    send(2'b00, 5'd3); wait_done();
    expect_cmd(2'b00, 4, 0, 0, 5'd7);
    send(2'b01, 5'd7); wait_done();
    expect_cmd(2'b00, 0, 0, 0, 5'd7);
    send(2'b01, 5'd7); wait_done();

    // SWEEP N=1 and N=0 from 2
    expect_cmd(2'b00, 0, 0, 1, 5'd2);
    send(2'b00, 5'd2); wait_done();
    expect_cmd(2'b00, 29, 31, 0, 5'd0);
    send(2'b10, 5'd1); wait_done();
    expect_cmd(2'b00, 0, 0, 1, 5'd2);
    send(2'b00, 5'd2); wait_done();
    expect_cmd(2'b00, 29, 31, 0, 5'd0);
    send(2'b10, 5'd0); wait_done();

    // GOTO 20 from 10, abort after the third up pulse
    expect_cmd(2'b00, 0, 0, 1, 5'd10);
    send(2'b00, 5'd10); wait_done();
    expect_cmd(2'b01, 3, 0, 0, 5'd13);
    send(2'b01, 5'd20);
    ups = 0; n = 0;
    while (ups < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (up) ups++;
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 5'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done();

    // Stuck counter during GOTO 5 from 0
    expect_cmd(2'b00, 0, 0, 1, 5'd0);
    send(2'b00, 5'd0); wait_done();
    hold = 1'b1;
    expect_cmd(2'b10, 1, 0, 0, 5'd0);
    send(2'b01, 5'd5); wait_done();
    hold = 1'b0;

    // ABORT in IDLE is ignored: no done, ready stays high
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b11;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    chk("idle_abort_ready", int'(cmd_ready), 1);
    chk("idle_abort_busy", int'(busy), 0);

    // Sweep with a command offered while busy, then reset mid-sweep
    expect_cmd(2'b00, 0, 0, 1, 5'd5);
    send(2'b00, 5'd5); wait_done();
    expect_cmd(2'b00, 0, 0, 0, 5'd0);
    send(2'b10, 5'd3);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 5'd9;
    repeat (3) begin
      @(negedge clk);
      chk("busy_not_ready", int'(cmd_ready), 0);
    end
    cmd_valid = 1'b0;
    repeat (12) @(negedge clk);
    sb_q.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_strobes", int'(load) + int'(up) + int'(down), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_ready", int'(cmd_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", int'(cmd_ready), 1);
    chk("midrst_no_done", int'(done), 0);

    // SWEEP from all-ones: zero up steps
    expect_cmd(2'b00, 0, 0, 1, 5'd31);
    send(2'b00, 5'd31); wait_done();
    expect_cmd(2'b00, 0, 31, 0, 5'd0);
    send(2'b10, 5'd1); wait_done();

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
